cart_scc_mapper: RTL

CART_SCC_MAPPER -- requirements
Module: cart_scc_mapper

---
 rtl/cart_scc_mapper.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cart_scc_mapper.sv
`default_nettype none
// cart_scc_mapper: Konami SCC/SCC+ cartridge bank mapper with a wave-engine request handshake.
// Build option SCC_PLUS_EN adds the mode register, RAM pages and the SCC+ register window.
module cart_scc_mapper #(
  parameter int BANK_W = 8,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_size,
  input  logic [15:0]       addr,
  input  logic [7:0]        d_from_cpu,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              scc_req,
  output logic              scc_wr,
  output logic [7:0]        scc_addr,
  output logic [7:0]        scc_dbo,
  input  logic              scc_ack,
  output logic              scc_plus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_COPY = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [BANK_W-1:0] bank_q [4];
  logic [1:0]        state_q, state_d;
  logic [7:0]        saddr_q, saddr_d;
  logic [7:0]        sdbo_q, sdbo_d;
  logic [4:0]        lo_q, lo_d;
  logic              swr_q, swr_d;
  logic              copy_q, copy_d;
  logic              cpu_ack_q, cpu_ack_d;

  // Mode bits: [4] SCC+ mode, [3] all pages RAM, [2:0] pages 0-2 RAM
  logic [4:0]        w_mode;
  logic [1:0]        w_page;
  logic              w_in_cart, w_bank_hit, w_mode_hit, w_page_ram, w_plus;
  logic              w_win, w_copy, w_wr_acc;
  logic [3:0]        w_ram_map;
  logic [7:0]        w_off, w_scc_off;
  logic [ADDR_W-1:0] w_bank_ext, w_mask;

  // 4000h/6000h/8000h/A000h pages map to {addr[15], addr[13]}
  assign w_page     = {addr[15], addr[13]};
  assign w_in_cart  = addr[15] ^ addr[14];
  assign w_bank_hit = w_in_cart && (addr[12:11] == 2'b10);
  assign w_mode_hit = (addr[15:1] == 15'h5FFF);
  assign w_wr_acc   = cs && wr;
  assign w_ram_map  = {1'b0, w_mode[2:0]};
  assign w_page_ram = w_mode[3] || w_ram_map[w_page];
  assign w_plus     = w_mode[4];
  assign scc_plus   = w_plus;

  assign w_bank_ext = {{(ADDR_W-BANK_W){1'b0}}, bank_q[w_page]};
  assign w_mask     = (rom_size >> 13) - ADDR_W'(1);
  assign mem_addr   = ((w_bank_ext & w_mask) << 13) | {{(ADDR_W-13){1'b0}}, addr[12:0]};

`ifdef SCC_PLUS_EN
  logic [4:0] mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 5'h00;
    end else if (w_wr_acc && w_mode_hit) begin
      mode_q <= {d_from_cpu[5:4], d_from_cpu[2:0]};
    end
  end

  assign w_mode = mode_q;
  assign mem_wr = w_wr_acc && w_in_cart && w_page_ram;
`else
  assign w_mode = 5'h00;
  assign mem_wr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) bank_q[i] <= BANK_W'(i);
    end else if (w_wr_acc && w_bank_hit && !w_page_ram) begin
      bank_q[w_page] <= BANK_W'(d_from_cpu);
    end
  end

  assign w_off     = addr[7:0];
  assign w_win     = w_plus ? ((addr[15:8] == 8'hB8) && bank_q[3][7])
                            : ((addr[15:8] == 8'h98) && (bank_q[2][5:0] == 6'h3F));
  assign w_scc_off = (!w_plus && w_off[7]) ? (w_off ^ 8'h20) : w_off;
  // Channel 4 shares channel 5's waveform in plain SCC mode, so its writes are mirrored
  assign w_copy    = !w_plus && wr && (w_off[7:5] == 3'b011);

  always_comb begin
    state_d   = state_q;
    saddr_d   = saddr_q;
    sdbo_d    = sdbo_q;
    lo_d      = lo_q;
    swr_d     = swr_q;
    copy_d    = copy_q;
    cpu_ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs && (rd || wr) && w_win) begin
          state_d = S_REQ;
          saddr_d = w_scc_off;
          sdbo_d  = d_from_cpu;
          lo_d    = addr[4:0];
          swr_d   = wr;
          copy_d  = w_copy;
        end
      end
      S_REQ: begin
        if (scc_ack) begin
          if (copy_q) begin
            state_d = S_COPY;
          end else begin
            state_d   = S_HOLD;
            cpu_ack_d = 1'b1;
          end
        end
      end
      S_COPY: begin
        if (scc_ack) begin
          state_d   = S_HOLD;
          cpu_ack_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!rd && !wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      saddr_q   <= 8'h00;
      sdbo_q    <= 8'h00;
      lo_q      <= 5'h00;
      swr_q     <= 1'b0;
      copy_q    <= 1'b0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saddr_q   <= saddr_d;
      sdbo_q    <= sdbo_d;
      lo_q      <= lo_d;
      swr_q     <= swr_d;
      copy_q    <= copy_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  assign scc_req  = (state_q == S_REQ) || (state_q == S_COPY);
  assign scc_wr   = swr_q;
  assign scc_dbo  = sdbo_q;
  assign scc_addr = (state_q == S_COPY) ? {3'b100, lo_q} : saddr_q;
  assign cpu_ack  = cpu_ack_q;

endmodule
`default_nettype wire
